// File: rtl/sd_block_streamer.sv
// Streams 512-byte SD blocks into the audio sample FIFO, refilling whenever the
// FIFO level drops below the low-water mark, until the stop address is reached.
module sd_block_streamer #(
  parameter int BLOCK_BYTES = 512,
  parameter int LOW_WATER   = 50,
  parameter int COUNT_W     = 14
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        start_adr,
  input  logic [31:0]        stop_adr,
  input  logic               sd_ready,
  input  logic               sd_byte_available,
  input  logic [7:0]         sd_dout,
  output logic               sd_rd,
  output logic [31:0]        sd_adr,
  input  logic [COUNT_W-1:0] fifo_count,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [7:0]         fifo_din,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               overflow,
  output logic [15:0]        blocks_read
);

  localparam int OFS_W = $clog2(BLOCK_BYTES);
  localparam logic [31:0]        BLK_INC    = 32'(BLOCK_BYTES);
  localparam logic [31:0]        ALIGN_MASK = 32'(BLOCK_BYTES - 1);
  localparam logic [OFS_W-1:0]   LAST_BYTE  = OFS_W'(BLOCK_BYTES - 1);
  localparam logic [COUNT_W-1:0] LOW_MARK   = COUNT_W'(LOW_WATER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ISSUE  = 3'd2,
    S_RECV   = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [31:0]      blk_adr_r;
  logic [31:0]      stop_adr_r;
  logic [OFS_W-1:0] byte_cnt_r;
  logic             byte_avail_r;
  logic             drain_r;

  logic        args_bad_s;
  logic        accept_s;
  logic        byte_edge_s;
  logic        last_byte_s;
  logic        wr_s;
  logic [31:0] blk_adr_inc_s;

  // Decode of start arguments, byte strobe edge and the write decision.
  always_comb begin
    args_bad_s    = (|(start_adr & ALIGN_MASK)) | (|(stop_adr & ALIGN_MASK)) |
                    (stop_adr <= start_adr);
    accept_s      = (state_r == S_IDLE) & start;
    byte_edge_s   = (state_r == S_RECV) & sd_byte_available & ~byte_avail_r;
    last_byte_s   = byte_edge_s & (byte_cnt_r == LAST_BYTE);
    wr_s          = byte_edge_s & ~drain_r & ~fifo_full;
    blk_adr_inc_s = blk_adr_r + BLK_INC;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= S_IDLE;
    else          state_r <= state_s;
  end

  // Next-state logic; an abort while the card is mid-block only drains it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start && !args_bad_s) state_s = S_WAIT;
        else                      state_s = S_IDLE;
      end
      S_WAIT: begin
        if (abort)                                 state_s = S_FINISH;
        else if (sd_ready && fifo_count < LOW_MARK) state_s = S_ISSUE;
        else                                       state_s = S_WAIT;
      end
      S_ISSUE: begin
        if (!sd_ready) state_s = S_RECV;
        else           state_s = S_ISSUE;
      end
      S_RECV: begin
        if (last_byte_s) state_s = (drain_r || abort) ? S_FINISH : S_NEXT;
        else             state_s = S_RECV;
      end
      S_NEXT: begin
        if (abort || blk_adr_inc_s >= stop_adr_r) state_s = S_FINISH;
        else                                      state_s = S_WAIT;
      end
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Datapath: addresses, counters, drain flag and byte-strobe history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_adr_r    <= 32'd0;
      stop_adr_r   <= 32'd0;
      byte_cnt_r   <= '0;
      byte_avail_r <= 1'b0;
      drain_r      <= 1'b0;
    end else begin
      byte_avail_r <= sd_byte_available;
      if (accept_s) begin
        blk_adr_r  <= start_adr;
        stop_adr_r <= stop_adr;
      end else if (state_r == S_NEXT) begin
        blk_adr_r  <= blk_adr_inc_s;
      end
      if (state_r == S_ISSUE)  byte_cnt_r <= '0;
      else if (byte_edge_s)    byte_cnt_r <= byte_cnt_r + 1'b1;
      if (state_s == S_FINISH || state_r == S_IDLE)               drain_r <= 1'b0;
      else if (abort && (state_r == S_ISSUE || state_r == S_RECV)) drain_r <= 1'b1;
    end
  end

  // Registered outputs, derived from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_rd       <= 1'b0;
      sd_adr      <= 32'd0;
      fifo_wr_en  <= 1'b0;
      fifo_din    <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      overflow    <= 1'b0;
      blocks_read <= 16'd0;
    end else begin
      sd_rd      <= (state_s == S_ISSUE);
      busy       <= (state_s != S_IDLE) && (state_s != S_FINISH);
      done       <= (state_s == S_FINISH) || (accept_s && args_bad_s);
      fifo_wr_en <= wr_s;
      if (wr_s) fifo_din <= sd_dout;
      if (state_s == S_ISSUE)                            sd_adr <= blk_adr_r;
      else if (state_s == S_FINISH || state_s == S_IDLE) sd_adr <= 32'd0;
      if (accept_s) begin
        error       <= args_bad_s;
        overflow    <= 1'b0;
        blocks_read <= 16'd0;
      end else begin
        if (byte_edge_s && !drain_r && fifo_full) overflow <= 1'b1;
        if (state_r == S_NEXT && blocks_read != 16'hFFFF)
          blocks_read <= blocks_read + 16'd1;
      end
    end
  end

endmodule
